// File: rtl/array_sequencer.sv
// Instruction sequencer for the systolic array: pops one 64-bit instruction, decodes it and
// emits the cycle-by-cycle memory/array command stream. Every output is a registered flop.
module array_sequencer #(
  parameter int ARRAY_N    = 4,
  parameter int ROW_WIDTH  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [63:0]           instr_data,
  output logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic                  w_load_en,
  output logic [ROW_WIDTH-1:0]  w_row,
  output logic                  x_valid,
  output logic                  compute_en,
  output logic                  acc_clear,
  output logic                  out_shift_en,
  output logic                  op_done,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal_op
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_LOAD_W, S_STREAM, S_DRAIN, S_STORE, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_LOAD_W  = 4'h1;
  localparam logic [3:0] OP_COMPUTE = 4'h3;
  localparam logic [3:0] OP_STORE   = 4'h4;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam logic [LEN_WIDTH-1:0] ROW_LAST   = LEN_WIDTH'(ARRAY_N - 1);
  localparam logic [LEN_WIDTH-1:0] DRAIN_LAST = LEN_WIDTH'(2 * ARRAY_N - 3);

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [3:0]            opcode_q, opcode_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  clear_q, clear_d;

  logic                  instr_ready_q, instr_ready_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic                  w_load_en_q, w_load_en_d;
  logic [ROW_WIDTH-1:0]  w_row_q, w_row_d;
  logic                  x_valid_q, x_valid_d;
  logic                  compute_en_q, compute_en_d;
  logic                  acc_clear_q, acc_clear_d;
  logic                  out_shift_en_q, out_shift_en_d;
  logic                  op_done_q, op_done_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic                  illegal_op_q, illegal_op_d;

  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  unused_reserved;

  assign unused_reserved = ^instr_data[30:0];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    opcode_d       = opcode_q;
    base_d         = base_q;
    clear_d        = clear_q;
    instr_ready_d  = 1'b0;
    mem_addr_d     = '0;
    mem_rd_en_d    = 1'b0;
    mem_wr_en_d    = 1'b0;
    w_load_en_d    = 1'b0;
    w_row_d        = '0;
    x_valid_d      = 1'b0;
    compute_en_d   = 1'b0;
    acc_clear_d    = 1'b0;
    out_shift_en_d = 1'b0;
    op_done_d      = 1'b0;
    halted_d       = halted_q;
    illegal_op_d   = illegal_op_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          state_d  = S_DECODE;
          opcode_d = instr_data[63:60];
          base_d   = ADDR_WIDTH'(instr_data[59:44]);
          len_d    = LEN_WIDTH'(instr_data[43:32]);
          clear_d  = instr_data[31];
        end
      end
      S_DECODE: begin
        cnt_d = '0;
        case (opcode_q)
          OP_NOP: begin
            state_d   = S_IDLE;
            op_done_d = 1'b1;
          end
          OP_LOAD_W:  state_d = S_LOAD_W;
          OP_COMPUTE: state_d = (len_q == '0) ? S_DRAIN : S_STREAM;
          OP_STORE:   state_d = S_STORE;
          OP_HALT: begin
            state_d   = S_HALT;
            op_done_d = 1'b1;
          end
          default: begin
            state_d      = S_IDLE;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      S_LOAD_W, S_STORE: begin
        if (cnt_q == ROW_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (cnt_q == len_q - LEN_WIDTH'(1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Outputs describe the beat that the next state/counter pair represents.
    beat_addr = base_q + ADDR_WIDTH'(cnt_d);
    case (state_d)
      S_IDLE: instr_ready_d = (state_q != S_DECODE);
      S_LOAD_W: begin
        mem_rd_en_d = 1'b1;
        w_load_en_d = 1'b1;
        w_row_d     = cnt_d[ROW_WIDTH-1:0];
        mem_addr_d  = beat_addr;
        op_done_d   = (cnt_d == ROW_LAST);
      end
      S_STREAM: begin
        x_valid_d    = 1'b1;
        compute_en_d = 1'b1;
        mem_rd_en_d  = 1'b1;
        mem_addr_d   = beat_addr;
        acc_clear_d  = clear_q && (cnt_d == '0);
      end
      S_DRAIN: begin
        compute_en_d = 1'b1;
        op_done_d    = (cnt_d == DRAIN_LAST);
      end
      S_STORE: begin
        out_shift_en_d = 1'b1;
        mem_wr_en_d    = 1'b1;
        mem_addr_d     = beat_addr;
        op_done_d      = (cnt_d == ROW_LAST);
      end
      S_HALT:  halted_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      len_q          <= '0;
      opcode_q       <= '0;
      base_q         <= '0;
      clear_q        <= 1'b0;
      instr_ready_q  <= 1'b0;
      mem_addr_q     <= '0;
      mem_rd_en_q    <= 1'b0;
      mem_wr_en_q    <= 1'b0;
      w_load_en_q    <= 1'b0;
      w_row_q        <= '0;
      x_valid_q      <= 1'b0;
      compute_en_q   <= 1'b0;
      acc_clear_q    <= 1'b0;
      out_shift_en_q <= 1'b0;
      op_done_q      <= 1'b0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
      illegal_op_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      opcode_q       <= opcode_d;
      base_q         <= base_d;
      clear_q        <= clear_d;
      instr_ready_q  <= instr_ready_d;
      mem_addr_q     <= mem_addr_d;
      mem_rd_en_q    <= mem_rd_en_d;
      mem_wr_en_q    <= mem_wr_en_d;
      w_load_en_q    <= w_load_en_d;
      w_row_q        <= w_row_d;
      x_valid_q      <= x_valid_d;
      compute_en_q   <= compute_en_d;
      acc_clear_q    <= acc_clear_d;
      out_shift_en_q <= out_shift_en_d;
      op_done_q      <= op_done_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
      illegal_op_q   <= illegal_op_d;
    end
  end

  assign instr_ready  = instr_ready_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign w_load_en    = w_load_en_q;
  assign w_row        = w_row_q;
  assign x_valid      = x_valid_q;
  assign compute_en   = compute_en_q;
  assign acc_clear    = acc_clear_q;
  assign out_shift_en = out_shift_en_q;
  assign op_done      = op_done_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign illegal_op   = illegal_op_q;

endmodule

// File: doc/array_sequencer.md
Name: array_sequencer

Overview:
Instruction sequencer between the instruction FIFO and the systolic array datapath. Pops one 64-bit instruction at a time over a valid/ready handshake and decodes it. Then issues a cycle-by-cycle command stream: operand-memory addresses and strobes, weight-row loads, input-vector streaming, array drain, and result shift-out. Owns the array's timing; the datapath and memories only follow its strobes.

Parameters:
ARRAY_N, 4, array dimension (rows = cols); weight load and store last ARRAY_N beats
ROW_WIDTH, 2, width of w_row; must equal clog2(ARRAY_N)
ADDR_WIDTH, 16, operand memory address width
LEN_WIDTH, 12, width of instruction length field

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  FIFO has an instruction on instr_data
instr_data  in  64  instruction word
instr_ready  out  1  sequencer accepts instr_data this cycle
mem_addr  out  ADDR_WIDTH  operand memory address
mem_rd_en  out  1  memory read strobe
mem_wr_en  out  1  memory write strobe (result store)
w_load_en  out  1  load weight row w_row from memory read data
w_row  out  ROW_WIDTH  weight row index
x_valid  out  1  input vector beat into array
compute_en  out  1  array advances (stream and drain)
acc_clear  out  1  one-cycle accumulator clear
out_shift_en  out  1  shift one result row out of array
op_done  out  1  one-cycle pulse on last beat of any executed op
busy  out  1  state != IDLE
halted  out  1  HALT executed
illegal_op  out  1  sticky; undefined opcode seen

Behaviour:
- Instruction fields: [63:60] opcode, [59:44] base address, [43:32] length L, [31] clear flag, [30:0] reserved/ignored.
- Opcodes: 0 NOP, 1 LOAD_W, 3 COMPUTE, 4 STORE, F HALT; all others illegal.
- All outputs are registered and update on the same edge as the state. Reset drives every output to 0, state to IDLE and counters to 0, immediately and asynchronously, including mid-operation. No pending beat resumes after reset.
- instr_ready rises on the first clk edge after rst deasserts; it is 1 only in IDLE.
- FSM states: IDLE, DECODE, LOAD_W, STREAM, DRAIN, STORE, HALT.
- IDLE: on instr_valid & instr_ready, latch the instruction, go to DECODE, and drop instr_ready.
- DECODE (1 cycle):
  - NOP: return to IDLE, pulse op_done.
  - Illegal opcode: set illegal_op, return to IDLE, no op_done.
  - HALT: go to HALT.
  - Otherwise: go to the op state with beat counter cnt=0.
- First command beat is visible 2 cycles after the accept edge.
- LOAD_W: ARRAY_N beats. Each beat drives mem_rd_en=1, w_load_en=1, w_row=cnt, mem_addr=base+cnt.
- COMPUTE enters STREAM:
  - STREAM: L beats, each with x_valid=1, compute_en=1, mem_rd_en=1, mem_addr=base+cnt.
  - acc_clear=1 on the first STREAM beat only, and only if the clear flag is set.
  - DRAIN: then 2*ARRAY_N-2 beats with compute_en=1 only.
  - L=0: skip STREAM and go straight to DRAIN.
- STORE: ARRAY_N beats, each with out_shift_en=1, mem_wr_en=1, mem_addr=base+cnt.
- Address arithmetic is modulo 2^ADDR_WIDTH (wraps silently).
- The memory and array datapath absorb their own read latency; the sequencer does not delay w_load_en or x_valid.
- Last beat of an op:
  - op_done=1 in that same cycle.
  - The next edge returns to IDLE, clears all strobes and sets instr_ready.
  - Minimum spacing between accepts is 3 cycles (NOP); no back-to-back overlap between ops.
- HALT: terminal until reset. instr_ready=0, halted=1, busy=1, op_done pulses once on entry.
- instr_valid while not ready: data is ignored and not consumed; the FIFO must hold it.
- illegal_op clears only on reset.

Test Plan:
- Reset, then instr_valid held with NOP -> instr_ready 0 during rst, 1 one cycle after release; accepts every 3 cycles; op_done each; all strobes stay 0.
- LOAD_W base 0x0100, ARRAY_N=4 -> 4 beats with mem_addr 0x0100..0x0103, w_row 0..3, w_load_en=mem_rd_en=1; op_done on beat 3; instr_ready 1 the next cycle.
- COMPUTE base 0x0200, L=3, clear=1 -> acc_clear only on beat 0; 3 beats x_valid with addr 0x0200..0x0202, then 6 compute_en-only beats; op_done on the 9th beat. Repeat with L=0 -> 6 drain beats, no x_valid.
- STORE base 0xFFFE -> mem_addr FFFE, FFFF, 0000, 0001 with mem_wr_en and out_shift_en; no mem_rd_en.
- Opcode 0x7, then LOAD_W -> illegal_op set 2 cycles after accept and stays 1; no strobes or op_done for 0x7; LOAD_W executes normally.
- rst pulse on 2nd STREAM beat of L=10 COMPUTE -> all outputs 0 within the reset cycle. Then HALT -> halted=1, instr_ready stays 0 with valid asserted, until the next rst.
